// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings, flag layout, request payload
// and response-register states. Imported by the issuer front end.
package alu_pkg;

   localparam int unsigned ALU_W  = 32;
   localparam int unsigned OP_W   = 3;
   localparam int unsigned FLAG_W = 4;

   typedef enum logic [OP_W-1:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SLT = 3'b101
   } alu_op_e;

   typedef struct packed {
      logic z;
      logic n;
      logic c;
      logic v;
   } alu_flags_t;

   // Raw op is kept as plain bits so illegal encodings survive the queue.
   typedef struct packed {
      logic [OP_W-1:0]  op;
      logic [ALU_W-1:0] a;
      logic [ALU_W-1:0] b;
   } alu_req_t;

   typedef enum logic {
      RSP_EMPTY = 1'b0,
      RSP_FULL  = 1'b1
   } rsp_state_e;

   // Encodings above SLT (110, 111) have no defined operation.
   function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
      return op > OP_W'(OP_SLT);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered read/write pointers carrying an extra wrap
// bit, so full and empty are told apart without a separate counter.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push_i, wdata_i   write request and data (ignored when full)
//   pop_i             read request (ignored when empty)
//   rdata_o           head entry, combinational from storage
//   full_o, empty_o   status
//   count_o           occupancy, 0..DEPTH
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0]    wptr_q, wptr_d;
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign count_o = wptr_q - rptr_q;
   assign full_o  = (count_o == PW'(DEPTH));
   assign empty_o = (wptr_q == rptr_q);
   assign rdata_o = mem_q[rptr_q[AW-1:0]];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Pointer next-state
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (do_push) wptr_d = wptr_q + PW'(1);
      if (do_pop)  rptr_d = rptr_q + PW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Storage needs no reset: it is only read through a valid pointer.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Front end for a combinational ALU. Queues tagged requests, drives the ALU
// from the queue head, captures the ALU result into a response register and
// hands it downstream with the original tag.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req_valid/req_ready             request handshake
//   req_op, req_a, req_b, req_tag   request payload
//   alu_op, alu_a, alu_b            drive to the ALU (from queue head)
//   alu_y, alu_z/n/c/v              ALU result, same cycle
//   rsp_valid/rsp_ready             response handshake
//   rsp_y, rsp_flags, rsp_tag       captured result, {z,n,c,v}, tag
//   rsp_err                         request op was an illegal encoding
//   issued_cnt                      responses captured, wraps at 2^16
module alu_cmd_issuer
   import alu_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TAG_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [OP_W-1:0]   req_op,
   input  logic [ALU_W-1:0]  req_a,
   input  logic [ALU_W-1:0]  req_b,
   input  logic [TAG_W-1:0]  req_tag,
   output logic [OP_W-1:0]   alu_op,
   output logic [ALU_W-1:0]  alu_a,
   output logic [ALU_W-1:0]  alu_b,
   input  logic [ALU_W-1:0]  alu_y,
   input  logic              alu_z,
   input  logic              alu_n,
   input  logic              alu_c,
   input  logic              alu_v,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [ALU_W-1:0]  rsp_y,
   output logic [FLAG_W-1:0] rsp_flags,
   output logic [TAG_W-1:0]  rsp_tag,
   output logic              rsp_err,
   output logic [15:0]       issued_cnt
);

   localparam int unsigned CNT_W   = 16;
   localparam int unsigned REQ_W   = $bits(alu_req_t);
   localparam int unsigned ENTRY_W = REQ_W + TAG_W;
   localparam int unsigned FCNT_W  = $clog2(DEPTH) + 1;

   alu_req_t          wr_req;
   alu_req_t          head_req;
   logic [TAG_W-1:0]  head_tag;
   logic [ENTRY_W-1:0] fifo_rdata;
   logic              fifo_full;
   logic              fifo_empty;
   logic [FCNT_W-1:0] fifo_count;
   logic              fifo_nonempty;
   logic              push;
   logic              issue;

   rsp_state_e        state_q, state_d;
   logic [ALU_W-1:0]  rsp_y_q, rsp_y_d;
   alu_flags_t        rsp_flags_q, rsp_flags_d;
   logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
   logic              rsp_err_q, rsp_err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // Ready depends only on the registered occupancy: no same-cycle bypass.
   assign req_ready     = (fifo_count != FCNT_W'(DEPTH));
   assign push          = req_valid && !fifo_full;
   assign fifo_nonempty = !fifo_empty;

   assign wr_req.op = req_op;
   assign wr_req.a  = req_a;
   assign wr_req.b  = req_b;

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .wdata_i ({wr_req, req_tag}),
      .pop_i   (issue),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign head_req = alu_req_t'(fifo_rdata[ENTRY_W-1:TAG_W]);
   assign head_tag = fifo_rdata[TAG_W-1:0];

   // ALU sees the queue head, or an idle ADD of zeros when nothing is queued.
   always_comb begin
      alu_op = OP_W'(OP_ADD);
      alu_a  = '0;
      alu_b  = '0;
      if (fifo_nonempty) begin
         alu_op = head_req.op;
         alu_a  = head_req.a;
         alu_b  = head_req.b;
      end
   end

   // Response register control and capture
   always_comb begin
      state_d     = state_q;
      issue       = 1'b0;
      rsp_y_d     = rsp_y_q;
      rsp_flags_d = rsp_flags_q;
      rsp_tag_d   = rsp_tag_q;
      rsp_err_d   = rsp_err_q;
      cnt_d       = cnt_q;

      case (state_q)
         RSP_EMPTY: begin
            if (fifo_nonempty) begin
               issue   = 1'b1;
               state_d = RSP_FULL;
            end
         end
         RSP_FULL: begin
            if (rsp_ready) begin
               if (fifo_nonempty) issue   = 1'b1;
               else               state_d = RSP_EMPTY;
            end
         end
         default: state_d = RSP_EMPTY;
      endcase

      if (issue) begin
         rsp_y_d       = alu_y;
         rsp_flags_d.z = alu_z;
         rsp_flags_d.n = alu_n;
         rsp_flags_d.c = alu_c;
         rsp_flags_d.v = alu_v;
         rsp_tag_d     = head_tag;
         rsp_err_d     = op_is_illegal(head_req.op);
         cnt_d         = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RSP_EMPTY;
         rsp_y_q     <= '0;
         rsp_flags_q <= '0;
         rsp_tag_q   <= '0;
         rsp_err_q   <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         rsp_y_q     <= rsp_y_d;
         rsp_flags_q <= rsp_flags_d;
         rsp_tag_q   <= rsp_tag_d;
         rsp_err_q   <= rsp_err_d;
         cnt_q       <= cnt_d;
      end
   end

   assign rsp_valid  = (state_q == RSP_FULL);
   assign rsp_y      = rsp_y_q;
   assign rsp_flags  = rsp_flags_q;
   assign rsp_tag    = rsp_tag_q;
   assign rsp_err    = rsp_err_q;
   assign issued_cnt = cnt_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a behavioural ALU attached.
module tb_alu_cmd_issuer;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [3:0]  req_tag;
   logic [2:0]  alu_op;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_y;
   logic        alu_z;
   logic        alu_n;
   logic        alu_c;
   logic        alu_v;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_y;
   logic [3:0]  rsp_flags;
   logic [3:0]  rsp_tag;
   logic        rsp_err;
   logic [15:0] issued_cnt;

   int n_cmp = 0;
   int n_mis = 0;

   alu_cmd_issuer #(.DEPTH(4), .TAG_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_tag    (req_tag),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_y      (alu_y),
      .alu_z      (alu_z),
      .alu_n      (alu_n),
      .alu_c      (alu_c),
      .alu_v      (alu_v),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_y      (rsp_y),
      .rsp_flags  (rsp_flags),
      .rsp_tag    (rsp_tag),
      .rsp_err    (rsp_err),
      .issued_cnt (issued_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: c is carry-out for ADD, borrow for SUB; illegal ops give 0.
   logic [32:0] sum_w;
   always_comb begin
      sum_w = '0;
      alu_y = '0;
      alu_c = 1'b0;
      alu_v = 1'b0;
      case (alu_op)
         3'b000: begin
            sum_w = {1'b0, alu_a} + {1'b0, alu_b};
            alu_y = sum_w[31:0];
            alu_c = sum_w[32];
            alu_v = (alu_a[31] == alu_b[31]) && (sum_w[31] != alu_a[31]);
         end
         3'b001: begin
            alu_y = alu_a - alu_b;
            alu_c = (alu_a < alu_b);
            alu_v = (alu_a[31] != alu_b[31]) && (alu_y[31] != alu_a[31]);
         end
         3'b010:  alu_y = alu_a & alu_b;
         3'b011:  alu_y = alu_a | alu_b;
         3'b100:  alu_y = alu_a ^ alu_b;
         3'b101:  alu_y = {31'b0, ($signed(alu_a) < $signed(alu_b))};
         default: alu_y = '0;
      endcase
      alu_z = (alu_y == 32'd0);
      alu_n = alu_y[31];
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: observed %0h, expected %0h", name, got, exp);
      end
   endtask

   // Offer one request starting at a negedge; returns at the negedge after acceptance.
   task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag);
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      req_tag   = tag;
      for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
      check("send_ready", 64'(req_ready), 64'd1);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Single request into an idle issuer: response appears one edge after accept.
   task automatic op_test(input string nm, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] tag,
                          input logic [31:0] exp_y, input logic [3:0] exp_f,
                          input logic exp_err);
      rsp_ready = 1'b1;
      send(op, a, b, tag);
      check({nm, "_early"}, 64'(rsp_valid), 64'd0);
      @(negedge clk);
      check({nm, "_valid"}, 64'(rsp_valid), 64'd1);
      check({nm, "_y"},     64'(rsp_y),     64'(exp_y));
      check({nm, "_flags"}, 64'(rsp_flags), 64'(exp_f));
      check({nm, "_tag"},   64'(rsp_tag),   64'(tag));
      check({nm, "_err"},   64'(rsp_err),   64'(exp_err));
      @(negedge clk);
   endtask

   initial begin
      int  stale;
      int  sent;
      int  recv;
      int  gaps;
      int  bad;
      logic primed;
      logic go;
      logic t5_acc;

      rst       = 1'b1;
      req_valid = 1'b0;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      req_tag   = '0;
      rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Reset values
      check("rst_req_ready", 64'(req_ready),  64'd1);
      check("rst_rsp_valid", 64'(rsp_valid),  64'd0);
      check("rst_rsp_y",     64'(rsp_y),      64'd0);
      check("rst_rsp_flags", 64'(rsp_flags),  64'd0);
      check("rst_rsp_tag",   64'(rsp_tag),    64'd0);
      check("rst_rsp_err",   64'(rsp_err),    64'd0);
      check("rst_cnt",       64'(issued_cnt), 64'd0);
      check("rst_alu_op",    64'(alu_op),     64'd0);
      check("rst_alu_a",     64'(alu_a),      64'd0);
      check("rst_alu_b",     64'(alu_b),      64'd0);

      // Single operations
      op_test("add", 3'b000, 32'hFFFF_FFFF, 32'd1, 4'd3, 32'd0,          4'b1010, 1'b0);
      op_test("sub", 3'b001, 32'h8000_0000, 32'd1, 4'd4, 32'h7FFF_FFFF,  4'b0001, 1'b0);
      op_test("slt", 3'b101, 32'hFFFF_FFFF, 32'd1, 4'd5, 32'd1,          4'b0000, 1'b0);
      op_test("xor", 3'b100, 32'hF0F0_00FF, 32'h0FF0_00F0, 4'd6, 32'hFF00_000F, 4'b0100, 1'b0);
      op_test("ill", 3'b111, 32'd5,         32'd7, 4'd9, 32'd0,          4'b1000, 1'b1);
      check("cnt_after_ops", 64'(issued_cnt), 64'd5);

      // Backpressure: 5 accepted, 6th waits, then all drain in order
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      rsp_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         req_valid = 1'b1;
         req_op    = 3'b000;
         req_a     = 32'(k);
         req_b     = 32'd1;
         req_tag   = 4'(k);
         check("bp_accept_ready", 64'(req_ready), 64'd1);
         @(negedge clk);
      end
      req_a   = 32'd5;
      req_tag = 4'd5;
      check("bp_full_ready", 64'(req_ready), 64'd0);
      repeat (3) begin
         @(negedge clk);
         check("bp_hold_ready", 64'(req_ready),  64'd0);
         check("bp_hold_tag",   64'(rsp_tag),    64'd0);
         check("bp_hold_y",     64'(rsp_y),      64'd1);
         check("bp_hold_cnt",   64'(issued_cnt), 64'd1);
      end
      rsp_ready = 1'b1;
      t5_acc    = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check("bp_drain_valid", 64'(rsp_valid), 64'd1);
         check("bp_drain_tag",   64'(rsp_tag),   64'(i));
         go = req_valid && req_ready;
         @(negedge clk);
         if (go) begin
            req_valid = 1'b0;
            t5_acc    = 1'b1;
         end
      end
      check("bp_tag5_accepted", 64'(t5_acc),     64'd1);
      check("bp_empty_after",   64'(rsp_valid),  64'd0);
      check("bp_cnt",           64'(issued_cnt), 64'd6);

      // Reset with requests queued discards them
      rsp_ready = 1'b0;
      send(3'b000, 32'd1, 32'd1, 4'd7);
      send(3'b000, 32'd2, 32'd1, 4'd8);
      send(3'b000, 32'd3, 32'd1, 4'd9);
      check("mid_rst_pending", 64'(rsp_valid), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_valid", 64'(rsp_valid),  64'd0);
      check("mid_rst_ready", 64'(req_ready),  64'd1);
      check("mid_rst_cnt",   64'(issued_cnt), 64'd0);
      rsp_ready = 1'b1;
      stale = 0;
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid) stale++;
      end
      check("mid_rst_stale", 64'(stale), 64'd0);

      // Stream 70000 requests: counter wraps, no bubbles once primed
      sent   = 0;
      recv   = 0;
      gaps   = 0;
      bad    = 0;
      primed = 1'b0;
      req_valid = 1'b1;
      req_op    = 3'b000;
      req_a     = 32'd0;
      req_b     = 32'd0;
      req_tag   = 4'd0;
      for (int cyc = 0; cyc < 70100 && recv < 70000; cyc++) begin
         if (rsp_valid) begin
            primed = 1'b1;
            if (rsp_y != 32'(recv)) bad++;
            recv++;
         end else if (primed) begin
            gaps++;
         end
         go = req_valid && req_ready;
         @(negedge clk);
         if (go) begin
            sent++;
            if (sent == 70000) begin
               req_valid = 1'b0;
            end else begin
               req_a   = 32'(sent);
               req_tag = 4'(sent);
            end
         end
      end
      check("stream_recv",  64'(recv),       64'd70000);
      check("stream_gaps",  64'(gaps),       64'd0);
      check("stream_data",  64'(bad),        64'd0);
      check("stream_wrap",  64'(issued_cnt), 64'd4464);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
